// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and constants for the systolic-array result path.
package dsp_sys_arr_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } ser_state_t;

   localparam int SNGL_FLT_SIZE = 32;
   localparam logic [7:0] FP_EXP_ALL_ONES = 8'hFF;

   // True for single-precision NaN or infinity (exponent field all ones).
   function automatic logic fp_is_special(input logic [SNGL_FLT_SIZE-1:0] f);
      return (f[30:23] == FP_EXP_ALL_ONES);
   endfunction

endpackage

// File: rtl/axis_result_serializer_ctr.sv
// ser_index_ctr: cascaded beat/column/row/total counters for the serializer.
// Every counter steps on adv and wraps at its terminal value; clr zeroes all.
module ser_index_ctr #(
   parameter int M  = 8,
   parameter int K  = 8,
   parameter int BW = 16,
   localparam int WIDX_W = (BW > 1) ? $clog2(BW) : 1,
   localparam int ROW_W  = $clog2(M) + 1,
   localparam int COL_W  = $clog2(K) + 1,
   localparam int TOT_W  = $clog2(M*K) + 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              adv,
   input  logic              clr,
   output logic [WIDX_W-1:0] widx,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic [TOT_W-1:0]  tot,
   output logic              widx_last,
   output logic              col_last,
   output logic              tot_last
);

   logic row_last;

   assign widx_last = (widx == WIDX_W'(BW - 1));
   assign col_last  = (col  == COL_W'(K - 1));
   assign row_last  = (row  == ROW_W'(M - 1));
   assign tot_last  = (tot  == TOT_W'(M*K - 1));

   // Advance all counters together; row only moves when the column wraps.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         widx <= '0;
         col  <= '0;
         row  <= '0;
         tot  <= '0;
      end else if (clr) begin
         widx <= '0;
         col  <= '0;
         row  <= '0;
         tot  <= '0;
      end else if (adv) begin
         widx <= widx_last ? '0 : widx + 1'b1;
         col  <= col_last  ? '0 : col + 1'b1;
         if (col_last)
            row <= row_last ? '0 : row + 1'b1;
         tot  <= tot_last  ? '0 : tot + 1'b1;
      end
   end

endmodule

// File: rtl/axis_result_serializer.sv
// axis_result_serializer: splits wide result beats of C (MxK, row-major
// floats) into one tagged 32-bit word per cycle and pulses mat_done after
// the last element. Optional macro SER_NAN_CHECK_EN enables the sticky
// NaN/Inf flag ser_err; without it ser_err is constant 0.
module axis_result_serializer
   import dsp_sys_arr_pkg::*;
#(
   parameter int M  = 8,
   parameter int K  = 8,
   parameter int BW = 16
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BW*SNGL_FLT_SIZE-1:0]   in_stream,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [SNGL_FLT_SIZE-1:0]      word_dat,
   output logic [$clog2(M):0]            word_row,
   output logic [$clog2(K):0]            word_col,
   output logic                          word_row_last,
   output logic                          word_last,
   output logic                          mat_done,
   output logic                          ser_err
);

   localparam int WIDX_W = (BW > 1) ? $clog2(BW) : 1;
   localparam int TOT_W  = $clog2(M*K) + 1;

   ser_state_t state, state_nxt;

   logic [BW-1:0][SNGL_FLT_SIZE-1:0] hold;
   logic [WIDX_W-1:0] widx;
   logic [TOT_W-1:0]  tot;
   logic widx_last, col_last, tot_last;
   logic armed;
   logic hold_ld, adv, clr;

   ser_index_ctr #(.M(M), .K(K), .BW(BW)) u_ctr (
      .clk       (clk),
      .nrst      (nrst),
      .adv       (adv),
      .clr       (clr),
      .widx      (widx),
      .col       (word_col),
      .row       (word_row),
      .tot       (tot),
      .widx_last (widx_last),
      .col_last  (col_last),
      .tot_last  (tot_last)
   );

   // Holds in_ready low through reset and the first cycle after release.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         armed <= 1'b0;
      else
         armed <= 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= S_EMPTY;
      else
         state <= state_nxt;
   end

   // Next state, input acceptance and counter strobes.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      adv       = 1'b0;
      clr       = 1'b0;
      case (state)
         S_EMPTY: begin
            in_ready = armed;
            if (in_valid && armed)
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (word_ready) begin
               adv = 1'b1;
               if (tot_last) begin
                  // Any padding words left in the beat are dropped here.
                  state_nxt = S_DONE;
               end else if (widx_last) begin
                  // Refill in the same cycle so beats chain without a bubble.
                  in_ready = 1'b1;
                  if (!in_valid)
                     state_nxt = S_EMPTY;
               end
            end
         end
         S_DONE: begin
            clr       = 1'b1;
            state_nxt = S_EMPTY;
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   assign hold_ld = in_valid & in_ready;

   // Beat holding register; word 0 sits in the low 32 bits.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         hold <= '0;
      else if (hold_ld)
         hold <= in_stream;
   end

   assign word_valid    = (state == S_DRAIN);
   assign word_dat      = word_valid ? hold[widx] : '0;
   assign word_row_last = word_valid & col_last;
   assign word_last     = word_valid & tot_last;
   assign mat_done      = (state == S_DONE);

`ifdef SER_NAN_CHECK_EN
   // Sticky NaN/Inf flag for the current matrix, cleared in the done cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         ser_err <= 1'b0;
      else if (state == S_DONE)
         ser_err <= 1'b0;
      else if (word_valid && word_ready && fp_is_special(word_dat))
         ser_err <= 1'b1;
   end
`else
   assign ser_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_result_serializer.sv
// Directed bench for axis_result_serializer with M=3, K=3, BW=4:
// nine words over three beats, the last beat carrying three padding words.
module tb_axis_result_serializer;

   localparam int M  = 3;
   localparam int K  = 3;
   localparam int BW = 4;
   localparam int NW = M*K;

`ifdef SER_NAN_CHECK_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   logic              clk;
   logic              nrst;
   logic              in_valid;
   logic              in_ready;
   logic [BW*32-1:0]  in_stream;
   logic              word_valid;
   logic              word_ready;
   logic [31:0]       word_dat;
   logic [$clog2(M):0] word_row;
   logic [$clog2(K):0] word_col;
   logic              word_row_last;
   logic              word_last;
   logic              mat_done;
   logic              ser_err;

   int n_tests = 0;
   int n_fail  = 0;

   axis_result_serializer #(.M(M), .K(K), .BW(BW)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_stream     (in_stream),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .word_dat      (word_dat),
      .word_row      (word_row),
      .word_col      (word_col),
      .word_row_last (word_row_last),
      .word_last     (word_last),
      .mat_done      (mat_done),
      .ser_err       (ser_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wv(input int i);
      return 32'h3F80_0000 + 32'(i);
   endfunction

   // One full matrix with word_ready=1; entered on a negedge with the DUT idle.
   task automatic run_matrix(input bit nan);
      logic [BW*32-1:0] bt [3];
      logic [31:0] ew [NW];
      int nb;
      bit exp_rdy;
      for (int i = 0; i < NW; i++) ew[i] = wv(i);
      if (nan) ew[2] = 32'h7FC0_0000;
      for (int b = 0; b < 3; b++)
         for (int w = 0; w < BW; w++)
            bt[b][w*32 +: 32] = (b*BW + w < NW) ? ew[b*BW + w] : 32'hDEAD_BEEF;
      word_ready = 1'b1;
      in_valid   = 1'b1;
      in_stream  = bt[0];
      chk("start_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      nb = 1;
      in_stream = bt[1];
      for (int i = 0; i < NW; i++) begin
         exp_rdy = ((i % BW) == BW-1) && (i != NW-1);
         chk("w_valid",    32'(word_valid),    32'd1);
         chk("w_dat",      word_dat,           ew[i]);
         chk("w_row",      32'(word_row),      32'(i / K));
         chk("w_col",      32'(word_col),      32'(i % K));
         chk("w_row_last", 32'(word_row_last), 32'((i % K) == K-1));
         chk("w_last",     32'(word_last),     32'(i == NW-1));
         chk("w_in_ready", 32'(in_ready),      32'(exp_rdy));
         chk("w_mat_done", 32'(mat_done),      32'd0);
         chk("w_ser_err",  32'(ser_err),       32'(NAN_EN && nan && i >= 3));
         @(negedge clk);
         if (exp_rdy) begin
            nb++;
            if (nb < 3) in_stream = bt[nb];
            else        in_valid  = 1'b0;
         end
      end
      chk("done_pulse",    32'(mat_done),   32'd1);
      chk("done_valid",    32'(word_valid), 32'd0);
      chk("done_in_ready", 32'(in_ready),   32'd0);
      chk("done_ser_err",  32'(ser_err),    32'(NAN_EN && nan));
      @(negedge clk);
      chk("post_done",     32'(mat_done),   32'd0);
      chk("post_valid",    32'(word_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready),   32'd1);
      chk("post_ser_err",  32'(ser_err),    32'd0);
   endtask

   initial begin
      logic [BW*32-1:0] b0, b1;
      for (int w = 0; w < BW; w++) begin
         b0[w*32 +: 32] = wv(w);
         b1[w*32 +: 32] = wv(BW + w);
      end
      nrst       = 1'b0;
      in_valid   = 1'b0;
      in_stream  = '0;
      word_ready = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_valid",    32'(word_valid),    32'd0);
      chk("rst_dat",      word_dat,           32'd0);
      chk("rst_row",      32'(word_row),      32'd0);
      chk("rst_col",      32'(word_col),      32'd0);
      chk("rst_row_last", 32'(word_row_last), 32'd0);
      chk("rst_last",     32'(word_last),     32'd0);
      chk("rst_done",     32'(mat_done),      32'd0);
      chk("rst_err",      32'(ser_err),       32'd0);
      chk("rst_in_ready", 32'(in_ready),      32'd0);
      nrst = 1'b1;
      @(negedge clk);

      // Full matrix: back-to-back beats, padding dropped, done pulse
      run_matrix(1'b0);

      // Second matrix with a 5-cycle stall on word 1
      in_valid  = 1'b1;
      in_stream = b0;
      @(negedge clk);
      chk("bp_w0", word_dat, wv(0));
      in_stream = b1;
      @(negedge clk);
      chk("bp_w1", word_dat, wv(1));
      word_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold_dat",   word_dat,           wv(1));
         chk("bp_hold_valid", 32'(word_valid),    32'd1);
         chk("bp_hold_row",   32'(word_row),      32'd0);
         chk("bp_hold_col",   32'(word_col),      32'd1);
         chk("bp_hold_rdy",   32'(in_ready),      32'd0);
      end
      word_ready = 1'b1;
      @(negedge clk);
      chk("bp_w2",       word_dat,           wv(2));
      chk("bp_w2_rlast", 32'(word_row_last), 32'd1);
      @(negedge clk);
      chk("bp_w3",       word_dat,           wv(3));
      chk("bp_w3_rdy",   32'(in_ready),      32'd1);
      @(negedge clk);
      chk("bp_w4",       word_dat,           wv(4));
      chk("bp_w4_row",   32'(word_row),      32'd1);
      chk("bp_w4_col",   32'(word_col),      32'd1);

      // Asynchronous reset in the middle of the matrix
      #1 nrst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(word_valid), 32'd0);
      chk("mid_rst_dat",   word_dat,        32'd0);
      chk("mid_rst_row",   32'(word_row),   32'd0);
      chk("mid_rst_col",   32'(word_col),   32'd0);
      chk("mid_rst_rdy",   32'(in_ready),   32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("rel_rdy",   32'(in_ready),   32'd1);
      chk("rel_valid", 32'(word_valid), 32'd0);

      // Fresh matrix from (0,0) with a NaN as the third word
      run_matrix(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
